// File: rtl/nf10_port_lookup_pkg.sv
// Shared types and the destination-mapping rule for the NIC output-port lookup.
package nf10_port_lookup_pkg;

  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_FORWARD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  localparam logic [1:0] MODE_NIC  = 2'd0;
  localparam logic [1:0] MODE_LOOP = 2'd1;
  localparam logic [1:0] MODE_DROP = 2'd2;

  // Returns {drop, dst}. MAC i (bit 2i) and CPU i (bit 2i+1) swap in NIC mode.
  function automatic logic [8:0] map_dst(input logic [7:0] src, input logic [1:0] mode,
                                         input logic [7:0] dflt, input int num_ports);
    logic [7:0] valid_mask;
    logic [7:0] swapped;
    logic [3:0] ones;
    valid_mask = '0;
    swapped    = '0;
    ones       = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < 2 * num_ports) valid_mask[i] = 1'b1;
      ones = ones + {3'b000, src[i]};
    end
    for (int i = 0; i < 4; i++) begin
      swapped[2*i]   = src[2*i+1];
      swapped[2*i+1] = src[2*i];
    end
    if (mode == MODE_DROP)                                      map_dst = {1'b1, 8'h00};
    else if (src == 8'h00)                                      map_dst = {(dflt == 8'h00), dflt};
    else if (ones != 4'd1 || (src & ~valid_mask) != 8'h00)      map_dst = {1'b1, 8'h00};
    else if (mode == MODE_LOOP)                                 map_dst = {1'b0, src & valid_mask};
    else                                                        map_dst = {1'b0, swapped & valid_mask};
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: the head entry is visible on dout whenever not empty.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 8,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             nearly_full
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      do_wr;
  logic                      do_rd;

  assign do_wr       = wr_en & ~nearly_full;
  assign do_rd       = rd_en & ~empty;
  assign empty       = (count == '0);
  // Threshold depends only on registered count, so upstream ready never sees downstream ready.
  assign nearly_full = (count >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{MAX_DEPTH_BITS{1'b0}}, do_wr} - {{MAX_DEPTH_BITS{1'b0}}, do_rd};
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/nf10_nic_port_lookup_multi.sv
// Output-port lookup: rewrites the tuser destination once per packet, drops invalid
// sources, and keeps saturating forward/drop packet counters.
module nf10_nic_port_lookup_multi
  import nf10_port_lookup_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_USER_WIDTH      = 128,
  parameter int SRC_PORT_POS      = 16,
  parameter int DST_PORT_POS      = 24,
  parameter int NUM_PORTS         = 4,
  parameter int FIFO_DEPTH_BITS   = 2
) (
  input  logic                           axi_aclk,
  input  logic                           axi_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_USER_WIDTH-1:0]        s_axis_tuser,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_USER_WIDTH-1:0]        m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  input  logic [1:0]                     cfg_mode,
  input  logic [7:0]                     cfg_default_dst,
  input  logic                           stat_clear,
  output logic [31:0]                    stat_fwd_pkts,
  output logic [31:0]                    stat_drop_pkts
);

  localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
  localparam int BEAT_W = C_AXIS_DATA_WIDTH + STRB_W + C_USER_WIDTH + 1;

  logic [BEAT_W-1:0]            fifo_din;
  logic [BEAT_W-1:0]            fifo_dout;
  logic                         fifo_empty;
  logic                         fifo_nearly_full;
  logic                         fifo_rd;
  logic [C_AXIS_DATA_WIDTH-1:0] head_data;
  logic [STRB_W-1:0]            head_strb;
  logic [C_USER_WIDTH-1:0]      head_user;
  logic                         head_last;

  state_t      state;
  logic [7:0]  dst_q;
  logic        hdr_hold;
  logic [31:0] fwd_cnt;
  logic [31:0] drop_cnt;
  logic        route_drop;
  logic [7:0]  route_dst;
  logic        fwd_valid;
  logic        drop_pop;
  logic [7:0]  out_dst;
  logic        fwd_hs;
  logic        fwd_done;
  logic        drop_done;

  assign fifo_din = {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};
  assign {head_data, head_strb, head_user, head_last} = fifo_dout;
  assign s_axis_tready = ~fifo_nearly_full;

  fallthrough_small_fifo #(
    .WIDTH          (BEAT_W),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_in_fifo (
    .clk         (axi_aclk),
    .rst         (axi_reset),
    .din         (fifo_din),
    .wr_en       (s_axis_tvalid),
    .rd_en       (fifo_rd),
    .dout        (fifo_dout),
    .empty       (fifo_empty),
    .nearly_full (fifo_nearly_full)
  );

  assign {route_drop, route_dst} =
    map_dst(head_user[SRC_PORT_POS +: 8], cfg_mode, cfg_default_dst, NUM_PORTS);

  // A header stalled by backpressure reuses its latched dst so outputs stay stable
  // even if the configuration changes while waiting.
  always_comb begin
    fwd_valid = 1'b0;
    drop_pop  = 1'b0;
    out_dst   = dst_q;
    case (state)
      ST_HEADER: if (!fifo_empty) begin
        if (hdr_hold)        fwd_valid = 1'b1;
        else if (route_drop) drop_pop  = 1'b1;
        else begin
          fwd_valid = 1'b1;
          out_dst   = route_dst;
        end
      end
      ST_FORWARD: fwd_valid = ~fifo_empty;
      ST_DROP:    drop_pop  = ~fifo_empty;
      default:    ;
    endcase
  end

  assign fwd_hs    = fwd_valid & m_axis_tready;
  assign fifo_rd   = fwd_hs | drop_pop;
  assign fwd_done  = fwd_hs & head_last;
  assign drop_done = drop_pop & head_last;

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state    <= ST_HEADER;
      dst_q    <= '0;
      hdr_hold <= 1'b0;
    end else begin
      case (state)
        ST_HEADER: begin
          if (fwd_valid) begin
            dst_q    <= out_dst;
            hdr_hold <= ~m_axis_tready;
            if (fwd_hs && !head_last) state <= ST_FORWARD;
          end else if (drop_pop && !head_last) begin
            state <= ST_DROP;
          end
        end
        ST_FORWARD: if (fwd_done)  state <= ST_HEADER;
        ST_DROP:    if (drop_done) state <= ST_HEADER;
        default:    state <= ST_HEADER;
      endcase
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      fwd_cnt  <= '0;
      drop_cnt <= '0;
    end else if (stat_clear) begin
      fwd_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (fwd_done && fwd_cnt != '1)   fwd_cnt  <= fwd_cnt + 32'd1;
      if (drop_done && drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  always_comb begin
    m_axis_tuser                    = head_user;
    m_axis_tuser[DST_PORT_POS +: 8] = out_dst;
  end

  assign m_axis_tdata   = head_data;
  assign m_axis_tstrb   = head_strb;
  assign m_axis_tlast   = head_last;
  assign m_axis_tvalid  = fwd_valid;
  assign stat_fwd_pkts  = fwd_cnt;
  assign stat_drop_pkts = drop_cnt;

endmodule
